pll_reset_ctrl: RTL and testbench

PLL_RESET_CTRL -- requirements
Module: pll_reset_ctrl

---
 rtl/pll_reset_ctrl.sv | 155 +++++++++++++++
 tb/tb_pll_reset_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_ctrl.sv
// PLL bring-up sequencer: holds the PLL in reset, waits for a synchronized lock,
// qualifies it for a stability window, and retries a bounded number of times.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_RST     | pll_rst driven high for RST_CYCLES cycles
// ST_WAIT    | pll_rst released, waiting up to LOCK_TIMEOUT cycles for lock
// ST_STABLE  | lock seen, needs STABLE_CYCLES uninterrupted lock cycles
// ST_LOCKED  | lock qualified, ready asserted
// ST_FAIL    | all attempts exhausted, PLL held in reset until relock/rst
module pll_reset_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRY     = 3
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       ready,
    output logic       fail,
    output logic       lock_lost,
    output logic [3:0] retry_cnt,
    output logic [2:0] state
);

    localparam int CNT_M1  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX = (CNT_M1 > STABLE_CYCLES) ? CNT_M1 : STABLE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_WAIT   = 3'd1,
        ST_STABLE = 3'd2,
        ST_LOCKED = 3'd3,
        ST_FAIL   = 3'd4
    } state_t;

    state_t        state_q;
    state_t        state_nx;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nx;
    logic [3:0]    retry_nx;
    logic          lost_nx;
    logic          sync1;
    logic          lock_s;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync1  <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            sync1  <= pll_lock;
            lock_s <= sync1;
        end
    end

    always_comb begin
        state_nx = state_q;
        retry_nx = retry_cnt;
        lost_nx  = 1'b0;
        case (state_q)
            // relock_req is deliberately ignored here so the PLL always gets a full reset pulse
            ST_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (relock_req) begin
                    state_nx = ST_RST;
                    retry_nx = 4'd0;
                end else if (lock_s) begin
                    state_nx = ST_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (retry_cnt < RETRY_MAX) begin
                        state_nx = ST_RST;
                        retry_nx = retry_cnt + 4'd1;
                    end else begin
                        state_nx = ST_FAIL;
                    end
                end
            end
            ST_STABLE: begin
                if (relock_req) begin
                    state_nx = ST_RST;
                    retry_nx = 4'd0;
                end else if (!lock_s) begin
                    state_nx = ST_WAIT;
                end else if (cnt_q == STABLE_LAST) begin
                    state_nx = ST_LOCKED;
                    retry_nx = 4'd0;
                end
            end
            ST_LOCKED: begin
                lost_nx = !lock_s;
                if (relock_req || !lock_s) begin
                    state_nx = ST_RST;
                    retry_nx = 4'd0;
                end
            end
            ST_FAIL: begin
                if (relock_req) begin
                    state_nx = ST_RST;
                    retry_nx = 4'd0;
                end
            end
            default: begin
                state_nx = ST_RST;
                retry_nx = 4'd0;
            end
        endcase
    end

    // Counter restarts on any state change; it only runs in the timed states.
    always_comb begin
        cnt_nx = cnt_q;
        if (state_nx != state_q) begin
            cnt_nx = '0;
        end else if (state_q == ST_RST || state_q == ST_WAIT || state_q == ST_STABLE) begin
            cnt_nx = cnt_q + CW'(1);
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q   <= ST_RST;
            cnt_q     <= '0;
            retry_cnt <= 4'd0;
            pll_rst   <= 1'b1;
            ready     <= 1'b0;
            fail      <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state_q   <= state_nx;
            cnt_q     <= cnt_nx;
            retry_cnt <= retry_nx;
            pll_rst   <= (state_nx == ST_RST) || (state_nx == ST_FAIL);
            ready     <= (state_nx == ST_LOCKED);
            fail      <= (state_nx == ST_FAIL);
            lock_lost <= lost_nx;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed bench for pll_reset_ctrl: a vector table for the main bring-up and
// retry flow, followed by hand-written multi-cycle corner sequences.
module tb_pll_reset_ctrl;

    logic       clk_in;
    logic       rst;
    logic       pll_lock;
    logic       relock_req;
    logic       pll_rst;
    logic       ready;
    logic       fail;
    logic       lock_lost;
    logic [3:0] retry_cnt;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;
    logic started = 1'b0;
    logic lost_prev = 1'b0;

    pll_reset_ctrl #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (32),
        .STABLE_CYCLES(8),
        .MAX_RETRY    (2)
    ) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .pll_lock  (pll_lock),
        .relock_req(relock_req),
        .pll_rst   (pll_rst),
        .ready     (ready),
        .fail      (fail),
        .lock_lost (lock_lost),
        .retry_cnt (retry_cnt),
        .state     (state)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic       rst;
        logic       lock;
        logic       relock;
        int         n;
        logic [2:0] st;
        logic       prst;
        logic       rdy;
        logic       fl;
        logic       lost;
        logic [3:0] rc;
    } vec_t;

    vec_t vecs[32];
    int   nvec = 0;

    task automatic add_vec(input logic r, input logic l, input logic rq, input int n,
                           input logic [2:0] st, input logic prst, input logic rdy,
                           input logic fl, input logic lost, input logic [3:0] rc);
        vecs[nvec] = '{r, l, rq, n, st, prst, rdy, fl, lost, rc};
        nvec++;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Packed layout: {state[2:0], pll_rst, ready, fail, lock_lost, retry_cnt[3:0]}
    task automatic chk(input string name, input logic [2:0] st, input logic prst,
                       input logic rdy, input logic fl, input logic lost, input logic [3:0] rc);
        logic [10:0] act;
        logic [10:0] exp;
        act = {state, pll_rst, ready, fail, lock_lost, retry_cnt};
        exp = {st, prst, rdy, fl, lost, rc};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got st=%0d prst=%b rdy=%b fail=%b lost=%b rc=%0d, want st=%0d prst=%b rdy=%b fail=%b lost=%b rc=%0d",
                     name, state, pll_rst, ready, fail, lock_lost, retry_cnt,
                     st, prst, rdy, fl, lost, rc);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Output consistency and single-cycle lock_lost, sampled mid-cycle.
    always @(negedge clk_in) begin
        if (started) begin
            checks++;
            if ((ready && pll_rst) || (ready && fail) || (lock_lost && lost_prev)) begin
                errors++;
                $display("FAIL invariant: ready=%b pll_rst=%b fail=%b lock_lost=%b prev_lost=%b",
                         ready, pll_rst, fail, lock_lost, lost_prev);
            end
            lost_prev = lock_lost;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int ticks;
        logic saw_wait;
        logic rdy_seen;

        rst = 1'b1;
        pll_lock = 1'b0;
        relock_req = 1'b0;

        //       rst lock rq  n   st prst rdy fail lost rc
        add_vec(1, 0, 0, 3,  0, 1, 0, 0, 0, 0);   // reset state
        add_vec(0, 0, 0, 3,  0, 1, 0, 0, 0, 0);   // counting RST
        add_vec(0, 0, 0, 1,  1, 0, 0, 0, 0, 0);   // 4th edge -> WAIT
        add_vec(0, 0, 0, 5,  1, 0, 0, 0, 0, 0);
        add_vec(0, 1, 0, 2,  1, 0, 0, 0, 0, 0);   // synchronizer latency
        add_vec(0, 1, 0, 1,  2, 0, 0, 0, 0, 0);   // STABLE
        add_vec(0, 1, 0, 7,  2, 0, 0, 0, 0, 0);
        add_vec(0, 1, 0, 1,  3, 0, 1, 0, 0, 0);   // LOCKED, ready
        add_vec(0, 1, 0, 5,  3, 0, 1, 0, 0, 0);
        add_vec(0, 0, 0, 2,  3, 0, 1, 0, 0, 0);   // drop not yet seen
        add_vec(0, 0, 0, 1,  0, 1, 0, 0, 1, 0);   // lock_lost pulse, RST
        add_vec(0, 0, 0, 1,  0, 1, 0, 0, 0, 0);   // pulse gone
        add_vec(0, 0, 0, 2,  0, 1, 0, 0, 0, 0);
        add_vec(0, 0, 0, 1,  1, 0, 0, 0, 0, 0);   // RST held 4 cycles
        add_vec(0, 0, 0, 31, 1, 0, 0, 0, 0, 0);   // last WAIT cycle
        add_vec(0, 0, 0, 1,  0, 1, 0, 0, 0, 1);   // timeout -> retry 1
        add_vec(0, 0, 0, 3,  0, 1, 0, 0, 0, 1);
        add_vec(0, 0, 0, 1,  1, 0, 0, 0, 0, 1);
        add_vec(0, 0, 0, 31, 1, 0, 0, 0, 0, 1);
        add_vec(0, 0, 0, 1,  0, 1, 0, 0, 0, 2);   // retry 2
        add_vec(0, 0, 0, 4,  1, 0, 0, 0, 0, 2);
        add_vec(0, 0, 0, 31, 1, 0, 0, 0, 0, 2);
        add_vec(0, 0, 0, 1,  4, 1, 0, 1, 0, 2);   // FAIL
        add_vec(0, 0, 0, 10, 4, 1, 0, 1, 0, 2);   // FAIL is sticky
        add_vec(0, 0, 1, 1,  0, 1, 0, 0, 0, 0);   // relock from FAIL
        add_vec(0, 0, 0, 1,  0, 1, 0, 0, 0, 0);
        add_vec(0, 0, 1, 1,  0, 1, 0, 0, 0, 0);   // relock ignored in RST
        add_vec(0, 0, 0, 1,  0, 1, 0, 0, 0, 0);
        add_vec(0, 0, 0, 1,  1, 0, 0, 0, 0, 0);   // RST still exactly 4

        for (int i = 0; i < nvec; i++) begin
            rst        = vecs[i].rst;
            pll_lock   = vecs[i].lock;
            relock_req = vecs[i].relock;
            for (int k = 0; k < vecs[i].n; k++) begin
                tick();
                started = 1'b1;
            end
            chk($sformatf("vec%0d", i), vecs[i].st, vecs[i].prst, vecs[i].rdy,
                vecs[i].fl, vecs[i].lost, vecs[i].rc);
        end
        relock_req = 1'b0;

        // Lock chatter: high 5, low 1, high again; STABLE must abort to WAIT.
        pll_lock = 1'b1;
        repeat (5) tick();
        chk("chatter_stable", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        saw_wait = 1'b0;
        rdy_seen = 1'b0;
        ticks = 0;
        while (!rdy_seen && ticks < 40) begin
            tick();
            ticks++;
            if (state == 3'd1) saw_wait = 1'b1;
            rdy_seen = ready;
        end
        chk_int("chatter_abort_to_wait", int'(saw_wait), 1);
        chk_int("chatter_ticks_to_ready", ticks, 11);

        // Relock coinciding with lock loss: lock_lost must still pulse.
        pll_lock = 1'b0;
        repeat (2) tick();
        chk("coincide_pre", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        chk("coincide_edge", 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        tick();
        chk("coincide_after", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

        // Relock in LOCKED with lock still present: no lock_lost.
        pll_lock = 1'b1;
        ticks = 0;
        while (!ready && ticks < 60) begin
            tick();
            ticks++;
        end
        chk("relock_locked_pre", 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        chk("relock_locked", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

        // rst pulse during STABLE restarts everything.
        ticks = 0;
        while (state != 3'd2 && ticks < 40) begin
            tick();
            ticks++;
        end
        repeat (2) tick();
        chk("stable_before_rst", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_in_stable", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        repeat (3) tick();
        chk("restart_rst", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        chk("restart_wait", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        ticks = 0;
        while (!ready && ticks < 30) begin
            tick();
            ticks++;
        end
        chk_int("restart_ticks_to_ready", ticks, 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
